wb_reg_file: RTL and testbench

//  Write-back end of the MEM/WB interface: consumes the WB-stage bundle, selects result data and

---
 rtl/wb_reg_file.sv | 87 ++++++++
 tb/tb_wb_reg_file.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_file.sv
// Write-back stage of the MEM/WB interface: selects result data and destination, commits
// into the GPR file with write-first bypass on both ID read ports, and counts committed writes.
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instruction_WB,
  input  logic [DATA_W-1:0] ALUResult_WB,
  input  logic [DATA_W-1:0] ReadDataFromMem_WB,
  input  logic [DATA_W-1:0] ReadData1_WB,
  input  logic              MemtoReg_WB,
  input  logic              RegWrite_WB,
  input  logic              RegWriteSel_WB,
  input  logic              Zero_WB,
  input  logic [1:0]        RegDst_WB,
  input  logic [1:0]        RegDataSel_WB,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              WBWriteEn,
  output logic [ADDR_W-1:0] WBWriteAddr,
  output logic [DATA_W-1:0] WBWriteData,
  output logic [31:0]       WBCount
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [31:0]       count_q, count_d;
  logic              dst_vld;
  logic              unused_instr;

  // Only the rt/rd fields of the instruction matter at write-back.
  assign unused_instr = ^{Instruction_WB[31:21], Instruction_WB[10:0]};

  always_comb begin
    WBWriteAddr = '0;
    dst_vld     = 1'b1;
    unique case (RegDst_WB)
      2'b00:   WBWriteAddr = ADDR_W'(Instruction_WB[20:16]);
      2'b01:   WBWriteAddr = ADDR_W'(Instruction_WB[15:11]);
      2'b10:   WBWriteAddr = ADDR_W'(31);
      default: dst_vld     = 1'b0;
    endcase
  end

  always_comb begin
    WBWriteData = ALUResult_WB;
    unique case (RegDataSel_WB)
      2'b00:   WBWriteData = MemtoReg_WB ? ReadDataFromMem_WB : ALUResult_WB;
      2'b01:   WBWriteData = ReadData1_WB;
      2'b10:   WBWriteData = {{(DATA_W-8){ReadDataFromMem_WB[7]}}, ReadDataFromMem_WB[7:0]};
      default: WBWriteData = {{(DATA_W-16){ReadDataFromMem_WB[15]}}, ReadDataFromMem_WB[15:0]};
    endcase
  end

  // r0 is hard-wired: writes to it are dropped and never counted.
  assign WBWriteEn = RegWrite_WB & dst_vld & (WBWriteAddr != '0) &
                     (~RegWriteSel_WB | Zero_WB);
  assign count_d   = count_q + 32'd1;
  assign WBCount   = count_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      count_q <= '0;
    end else if (WBWriteEn) begin
      regs_q[WBWriteAddr] <= WBWriteData;
      count_q             <= count_d;
    end
  end

  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    if (ReadReg1 == '0)                               ReadData1 = '0;
    else if (WBWriteEn && (WBWriteAddr == ReadReg1)) ReadData1 = WBWriteData;
  end

  always_comb begin
    ReadData2 = regs_q[ReadReg2];
    if (ReadReg2 == '0)                               ReadData2 = '0;
    else if (WBWriteEn && (WBWriteAddr == ReadReg2)) ReadData2 = WBWriteData;
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file: reset, destination/data selection, bypass, r0, conditional
// writes, mid-cycle reset and counter wrap.
module tb_wb_reg_file;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instruction_WB, ALUResult_WB, ReadDataFromMem_WB, ReadData1_WB;
  logic        MemtoReg_WB, RegWrite_WB, RegWriteSel_WB, Zero_WB;
  logic [1:0]  RegDst_WB, RegDataSel_WB;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2, WBWriteData, WBCount;
  logic        WBWriteEn;
  logic [4:0]  WBWriteAddr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  wb_reg_file dut (
    .Clk(Clk), .Reset(Reset), .Instruction_WB(Instruction_WB),
    .ALUResult_WB(ALUResult_WB), .ReadDataFromMem_WB(ReadDataFromMem_WB),
    .ReadData1_WB(ReadData1_WB), .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
    .RegWriteSel_WB(RegWriteSel_WB), .Zero_WB(Zero_WB), .RegDst_WB(RegDst_WB),
    .RegDataSel_WB(RegDataSel_WB), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WBWriteEn(WBWriteEn),
    .WBWriteAddr(WBWriteAddr), .WBWriteData(WBWriteData), .WBCount(WBCount)
  );

  always #5 Clk = ~Clk;

  task automatic idle();
    Instruction_WB = '0; ALUResult_WB = '0; ReadDataFromMem_WB = '0; ReadData1_WB = '0;
    MemtoReg_WB = 0; RegWrite_WB = 0; RegWriteSel_WB = 0; Zero_WB = 0;
    RegDst_WB = 2'b00; RegDataSel_WB = 2'b00;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic set_instr(input logic [4:0] rt, input logic [4:0] rd);
    Instruction_WB = {11'h5A5, rt, rd, 11'h2A3};
  endtask

  task automatic test_reset();
    idle(); Reset = 0; ReadReg1 = 0; ReadReg2 = 0;
    repeat (3) tick();
    for (int a = 0; a < 32; a++) begin
      ReadReg1 = 5'(a); ReadReg2 = 5'(31 - a); #1;
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
        errors++; $display("FAIL reset_read a=%0d got %h/%h expected 0", a, ReadData1, ReadData2);
      end
    end
    checks++;
    if (WBCount !== 32'h0) begin errors++; $display("FAIL reset_count got %h expected 0", WBCount); end
    @(negedge Clk); Reset = 1; tick();
    ReadReg1 = 5; #1;
    checks++;
    if (WBCount !== 32'h0 || ReadData1 !== 32'h0) begin
      errors++; $display("FAIL reset_release got cnt=%h rd=%h expected 0/0", WBCount, ReadData1);
    end
    exp_cnt = 0;
  endtask

  task automatic test_rd_bypass();
    idle(); set_instr(5'd3, 5'd5); RegWrite_WB = 1; RegDst_WB = 2'b01;
    ALUResult_WB = 32'h1234_5678; ReadDataFromMem_WB = 32'hDEAD_BEEF;
    ReadReg1 = 5; ReadReg2 = 5; #1;
    checks++;
    if (WBWriteEn !== 1'b1 || WBWriteAddr !== 5'd5 || WBWriteData !== 32'h1234_5678) begin
      errors++; $display("FAIL wb_outputs got en=%b addr=%0d data=%h expected 1/5/12345678",
                         WBWriteEn, WBWriteAddr, WBWriteData);
    end
    checks++;
    if (ReadData1 !== 32'h1234_5678 || ReadData2 !== 32'h1234_5678) begin
      errors++; $display("FAIL bypass got %h/%h expected 12345678", ReadData1, ReadData2);
    end
    tick(); idle(); exp_cnt++; #1;
    checks++;
    if (ReadData1 !== 32'h1234_5678 || WBCount !== exp_cnt) begin
      errors++; $display("FAIL array_read got %h cnt=%0d expected 12345678 cnt=%0d",
                         ReadData1, WBCount, exp_cnt);
    end
    // MemtoReg path into rt
    set_instr(5'd6, 5'd9); RegWrite_WB = 1; RegDst_WB = 2'b00; MemtoReg_WB = 1;
    ReadDataFromMem_WB = 32'hA5A5_0001; ALUResult_WB = 32'h1111_1111;
    tick(); idle(); exp_cnt++; ReadReg1 = 6; #1;
    checks++;
    if (ReadData1 !== 32'hA5A5_0001) begin
      errors++; $display("FAIL memtoreg got %h expected a5a50001", ReadData1);
    end
  endtask

  task automatic test_r0();
    idle(); set_instr(5'd0, 5'd7); RegWrite_WB = 1; RegDst_WB = 2'b00;
    ALUResult_WB = 32'hFFFF_FFFF; ReadReg1 = 0; ReadReg2 = 0; #1;
    checks++;
    if (WBWriteEn !== 1'b0 || ReadData1 !== 32'h0) begin
      errors++; $display("FAIL r0_write got en=%b rd=%h expected 0/0", WBWriteEn, ReadData1);
    end
    tick(); idle(); #1;
    checks++;
    if (ReadData2 !== 32'h0 || WBCount !== exp_cnt) begin
      errors++; $display("FAIL r0_after got rd=%h cnt=%0d expected 0 cnt=%0d", ReadData2, WBCount, exp_cnt);
    end
  endtask

  task automatic test_sext();
    idle(); set_instr(5'd1, 5'd8); RegWrite_WB = 1; RegDst_WB = 2'b01; RegDataSel_WB = 2'b10;
    ReadDataFromMem_WB = 32'h0000_0080;
    tick(); set_instr(5'd1, 5'd9); RegDataSel_WB = 2'b11; ReadDataFromMem_WB = 32'h0000_7FFF;
    tick(); set_instr(5'd1, 5'd11); RegDataSel_WB = 2'b11; ReadDataFromMem_WB = 32'h1234_8000;
    tick(); idle(); exp_cnt += 3;
    ReadReg1 = 8; ReadReg2 = 9; #1;
    checks++;
    if (ReadData1 !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext got %h expected ffffff80", ReadData1); end
    checks++;
    if (ReadData2 !== 32'h0000_7FFF) begin errors++; $display("FAIL lh_pos got %h expected 00007fff", ReadData2); end
    ReadReg1 = 11; #1;
    checks++;
    if (ReadData1 !== 32'hFFFF_8000) begin errors++; $display("FAIL lh_neg got %h expected ffff8000", ReadData1); end
    checks++;
    if (WBCount !== exp_cnt) begin errors++; $display("FAIL sext_count got %0d expected %0d", WBCount, exp_cnt); end
  endtask

  task automatic test_cond_write();
    idle(); set_instr(5'd1, 5'd10); RegWrite_WB = 1; RegDst_WB = 2'b01; RegWriteSel_WB = 1;
    Zero_WB = 0; RegDataSel_WB = 2'b01; ReadData1_WB = 32'h0000_BEEF; ReadReg1 = 10; #1;
    checks++;
    if (WBWriteEn !== 1'b0 || ReadData1 !== 32'h0) begin
      errors++; $display("FAIL movz_blocked got en=%b rd=%h expected 0/0", WBWriteEn, ReadData1);
    end
    tick(); Zero_WB = 1; ReadData1_WB = 32'h0000_CAFE; #1;
    checks++;
    if (WBWriteEn !== 1'b1 || ReadData1 !== 32'h0000_CAFE) begin
      errors++; $display("FAIL movz_taken got en=%b rd=%h expected 1/0000cafe", WBWriteEn, ReadData1);
    end
    tick(); idle(); exp_cnt++; #1;
    checks++;
    if (ReadData1 !== 32'h0000_CAFE || WBCount !== exp_cnt) begin
      errors++; $display("FAIL movz_commit got %h cnt=%0d expected 0000cafe cnt=%0d", ReadData1, WBCount, exp_cnt);
    end
    // link register and "no destination"
    set_instr(5'd2, 5'd3); RegWrite_WB = 1; RegDst_WB = 2'b10; ALUResult_WB = 32'h0040_0008;
    ReadReg2 = 31; #1;
    checks++;
    if (WBWriteAddr !== 5'd31 || ReadData2 !== 32'h0040_0008) begin
      errors++; $display("FAIL r31 got addr=%0d rd=%h expected 31/00400008", WBWriteAddr, ReadData2);
    end
    tick(); RegDst_WB = 2'b11; ALUResult_WB = 32'h7777_7777; ReadReg1 = 3; ReadReg2 = 2; #1;
    checks++;
    if (WBWriteEn !== 1'b0) begin errors++; $display("FAIL nodst got en=%b expected 0", WBWriteEn); end
    tick(); exp_cnt++;
    RegWrite_WB = 0; RegDst_WB = 2'b01; set_instr(5'd5, 5'd5); ALUResult_WB = 32'h9999_9999; #1;
    tick(); idle(); ReadReg1 = 5; #1;
    checks++;
    if (ReadData1 !== 32'h1234_5678 || ReadData2 !== 32'h0 || WBCount !== exp_cnt) begin
      errors++; $display("FAIL idle_no_write got r5=%h r2=%h cnt=%0d expected 12345678/0/%0d",
                         ReadData1, ReadData2, WBCount, exp_cnt);
    end
  endtask

  task automatic test_reset_midcycle();
    idle(); RegWrite_WB = 1; RegDst_WB = 2'b01;
    for (int r = 1; r <= 3; r++) begin
      set_instr(5'd0, 5'(r)); ALUResult_WB = 32'h100 + 32'(r); tick();
    end
    ReadReg1 = 2; RegWrite_WB = 0; #1;
    checks++;
    if (ReadData1 !== 32'h102) begin errors++; $display("FAIL pre_reset got %h expected 102", ReadData1); end
    // pending write present while reset drops between edges
    set_instr(5'd0, 5'd4); RegWrite_WB = 1; ALUResult_WB = 32'h444; ReadReg1 = 3; ReadReg2 = 1;
    #2 Reset = 0; #1;
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0 || WBCount !== 32'h0) begin
      errors++; $display("FAIL async_reset got %h/%h cnt=%h expected 0", ReadData1, ReadData2, WBCount);
    end
    tick(); RegWrite_WB = 0; ReadReg1 = 4; #1;
    checks++;
    if (ReadData1 !== 32'h0) begin errors++; $display("FAIL reset_drop got %h expected 0", ReadData1); end
    @(negedge Clk); Reset = 1; RegWrite_WB = 1; tick(); idle(); #1;
    checks++;
    if (ReadData1 !== 32'h444 || WBCount !== 32'd1) begin
      errors++; $display("FAIL post_reset_write got %h cnt=%0d expected 444 cnt=1", ReadData1, WBCount);
    end
  endtask

  task automatic test_count_wrap();
    @(negedge Clk);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (WBCount !== 32'hFFFF_FFFF) begin errors++; $display("FAIL preset got %h expected ffffffff", WBCount); end
    release dut.count_q;
    set_instr(5'd12, 5'd0); RegWrite_WB = 1; RegDst_WB = 2'b00; ALUResult_WB = 32'h5;
    tick(); idle(); ReadReg2 = 12; #1;
    checks++;
    if (WBCount !== 32'h0 || ReadData2 !== 32'h5) begin
      errors++; $display("FAIL wrap got cnt=%h r12=%h expected 0/5", WBCount, ReadData2);
    end
  endtask

  initial begin
    test_reset();
    test_rd_bypass();
    test_r0();
    test_sext();
    test_cond_write();
    test_reset_midcycle();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
